ysyx_25040101_wb_arb: RTL

Writeback arbiter and load scoreboard for the single register-file write port. Two producers share the write port: the EXU, which completes in one cycle and has fixed priority, and the LSU, whose load results arrive after a variable latency and are buffered when they lose arbitration. The block tracks destination registers with outstanding loads so the issue stage can stall on RAW/WAW hazards. Its write outputs drive the register file's `rd_wen_i` / `rd_addr_i` / `rd_data_i` directly.

---
 rtl/ysyx_25040101_wb_arb_if.sv | 42 ++++
 rtl/ysyx_25040101_wb_arb.sv | 114 +++++++++++
 2 files changed

// File: rtl/ysyx_25040101_wb_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040101_wb_arb_if
// Description : Writeback bus bundle: EXU/LSU producers, load issue, hazard
//               checks and the register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_25040101_wb_arb_if;
    logic        exu_valid_i;
    logic [4:0]  exu_rd_addr_i;
    logic [31:0] exu_rd_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_addr_i;
    logic [31:0] lsu_rd_data_i;
    logic        ld_issue_i;
    logic [4:0]  ld_issue_rd_i;
    logic [4:0]  chk_rs1_i;
    logic [4:0]  chk_rs2_i;
    logic [4:0]  chk_rd_i;
    logic        hazard_o;
    logic        rd_wen_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    modport slave (
        input  exu_valid_i, exu_rd_addr_i, exu_rd_data_i,
        input  lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
        input  ld_issue_i, ld_issue_rd_i,
        input  chk_rs1_i, chk_rs2_i, chk_rd_i,
        output lsu_ready_o, hazard_o, rd_wen_o, rd_addr_o, rd_data_o
    );

    modport master (
        output exu_valid_i, exu_rd_addr_i, exu_rd_data_i,
        output lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
        output ld_issue_i, ld_issue_rd_i,
        output chk_rs1_i, chk_rs2_i, chk_rd_i,
        input  lsu_ready_o, hazard_o, rd_wen_o, rd_addr_o, rd_data_o
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_25040101_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040101_wb_arb
// Description : Writeback arbiter (EXU fixed priority, LSU skid FIFO) with a
//               load scoreboard driving the issue-stage hazard signal.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040101_wb_arb #(
    parameter int DEPTH = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ysyx_25040101_wb_arb_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [4:0]  addr_mem_q [DEPTH];
    logic [4:0]  addr_mem_d [DEPTH];
    logic [31:0] data_mem_q [DEPTH];
    logic [31:0] data_mem_d [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0] busy_q, busy_d;
    logic        rd_wen_q, rd_wen_d;
    logic        rd_lsu_q, rd_lsu_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic empty, full, lsu_hs;

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign lsu_hs = bus.lsu_valid_i && !full;

    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_wen_d   = 1'b0;
        rd_lsu_d   = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;

        if (bus.exu_valid_i) begin
            rd_wen_d  = (bus.exu_rd_addr_i != 5'd0);
            rd_addr_d = bus.exu_rd_addr_i;
            rd_data_d = bus.exu_rd_data_i;
        end else if (!empty) begin
            rd_wen_d  = (addr_mem_q[rptr_q[AW-1:0]] != 5'd0);
            rd_lsu_d  = 1'b1;
            rd_addr_d = addr_mem_q[rptr_q[AW-1:0]];
            rd_data_d = data_mem_q[rptr_q[AW-1:0]];
            rptr_d    = rptr_q + PTR_ONE;
        end else if (lsu_hs) begin
            rd_wen_d  = (bus.lsu_rd_addr_i != 5'd0);
            rd_lsu_d  = 1'b1;
            rd_addr_d = bus.lsu_rd_addr_i;
            rd_data_d = bus.lsu_rd_data_i;
        end

        // Bypass only happens when the FIFO is empty and EXU is idle; otherwise buffer.
        if (lsu_hs && (bus.exu_valid_i || !empty)) begin
            addr_mem_d[wptr_q[AW-1:0]] = bus.lsu_rd_addr_i;
            data_mem_d[wptr_q[AW-1:0]] = bus.lsu_rd_data_i;
            wptr_d = wptr_q + PTR_ONE;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (rd_wen_q && rd_lsu_q) begin
            busy_d[rd_addr_q] = 1'b0;
        end
        // Applied after the clear so a same-edge set wins.
        if (bus.ld_issue_i && (bus.ld_issue_rd_i != 5'd0)) begin
            busy_d[bus.ld_issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            busy_q    <= '0;
            rd_wen_q  <= 1'b0;
            rd_lsu_q  <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            busy_q    <= busy_d;
            rd_wen_q  <= rd_wen_d;
            rd_lsu_q  <= rd_lsu_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    // busy_q[0] is never set, so a zero index contributes nothing.
    assign bus.hazard_o    = busy_q[bus.chk_rs1_i] | busy_q[bus.chk_rs2_i] | busy_q[bus.chk_rd_i];
    assign bus.lsu_ready_o = !full;
    assign bus.rd_wen_o    = rd_wen_q;
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.rd_data_o   = rd_data_q;
endmodule
`default_nettype wire
